// File: rtl/vga_timing_gen_param.sv
// Parametrised VGA timing generator: pixel enable, H/V counters, aligned sync/blank, gated RGB.
// Optional internal colour-bar source enabled by defining VGA_TEST_PATTERN_EN.
module vga_timing_gen_param #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned COLOR_W  = 8,
  parameter int unsigned CNT_W    = 10,
  parameter int unsigned HS_POL   = 0,
  parameter int unsigned VS_POL   = 0,
  parameter int unsigned PIPE_LAT = 1
) (
  input  logic               FPGA_Clock,
  input  logic               FPGA_Reset_N,
  input  logic [COLOR_W-1:0] R,
  input  logic [COLOR_W-1:0] G,
  input  logic [COLOR_W-1:0] B,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               Pattern_Sel,
`endif
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B,
  output logic               VGA_Clock,
  output logic               VGA_SYNC_N,
  output logic               VGA_BLANK_N,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic [CNT_W-1:0]   H_COUNT,
  output logic [CNT_W-1:0]   V_COUNT,
  output logic               Pixel_Req,
  output logic               Pixel_Tick,
  output logic               Frame_Start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = VS_BEG + V_SYNC;
  localparam int unsigned DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned PIPE_D  = (PIPE_LAT > 0) ? PIPE_LAT : 1;
`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned FLAG_W  = 3 + CNT_W;
`else
  localparam int unsigned FLAG_W  = 3;
`endif
  localparam logic HS_ON = 1'(HS_POL);
  localparam logic VS_ON = 1'(VS_POL);

  if ((64'(H_TOTAL) > (64'd1 << CNT_W)) || (64'(V_TOTAL) > (64'd1 << CNT_W))) begin : g_cnt_w_chk
    $error("CNT_W too small for H_TOTAL/V_TOTAL");
  end
  if ((CLK_DIV < 2) || ((CLK_DIV % 2) != 0)) begin : g_div_chk
    $error("CLK_DIV must be even and >= 2");
  end
  if (PIPE_LAT > 4) begin : g_lat_chk
    $error("PIPE_LAT must be 0..4");
  end

  logic [DIV_W-1:0]               div_q, div_d;
  logic                           tick_q, tick_d, vclk_q, vclk_d;
  logic                           start_q, start_d, frame_q, frame_d;
  logic [CNT_W-1:0]               h_q, h_d, v_q, v_d;
  logic [PIPE_D-1:0][FLAG_W-1:0]  pipe_q, pipe_d;
  logic                           blank_q, blank_d, hs_q, hs_d, vs_q, vs_d;
  logic [COLOR_W-1:0]             r_q, r_d, g_q, g_d, b_q, b_d;
  logic                           active_c, hs_raw_c, vs_raw_c;
  logic [FLAG_W-1:0]              flags_c, flags_dly_c;
  logic [COLOR_W-1:0]             src_r_c, src_g_c, src_b_c;
`ifdef VGA_TEST_PATTERN_EN
  logic [2:0]                     bar_c, bar_rgb_c;
`endif

  // Region decode on the undelayed counters
  assign active_c  = (h_q < CNT_W'(H_ACTIVE)) && (v_q < CNT_W'(V_ACTIVE));
  assign hs_raw_c  = (h_q >= CNT_W'(HS_BEG)) && (h_q < CNT_W'(HS_END));
  assign vs_raw_c  = (v_q >= CNT_W'(VS_BEG)) && (v_q < CNT_W'(VS_END));
`ifdef VGA_TEST_PATTERN_EN
  assign flags_c   = {h_q, vs_raw_c, hs_raw_c, active_c};
`else
  assign flags_c   = {vs_raw_c, hs_raw_c, active_c};
`endif
  assign flags_dly_c = (PIPE_LAT == 0) ? flags_c : pipe_q[PIPE_D-1];

  always_comb begin
    div_d   = (div_q == DIV_W'(CLK_DIV - 1)) ? '0 : div_q + DIV_W'(1);
    tick_d  = (div_q == DIV_W'(CLK_DIV - 1));
    vclk_d  = (div_q >= DIV_W'(CLK_DIV / 2));
    start_d = start_q;
    frame_d = 1'b0;
    h_d     = h_q;
    v_d     = v_q;
    pipe_d  = pipe_q;
    blank_d = blank_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    src_r_c = R;
    src_g_c = G;
    src_b_c = B;
`ifdef VGA_TEST_PATTERN_EN
    bar_c     = 3'((32'(flags_dly_c[FLAG_W-1:3]) * 32'd8) / H_ACTIVE);
    bar_rgb_c = 3'b000;
    case (bar_c)
      3'd0:    bar_rgb_c = 3'b111;
      3'd1:    bar_rgb_c = 3'b110;
      3'd2:    bar_rgb_c = 3'b011;
      3'd3:    bar_rgb_c = 3'b010;
      3'd4:    bar_rgb_c = 3'b101;
      3'd5:    bar_rgb_c = 3'b100;
      3'd6:    bar_rgb_c = 3'b001;
      default: bar_rgb_c = 3'b000;
    endcase
    if (Pattern_Sel) begin
      src_r_c = {COLOR_W{bar_rgb_c[2]}};
      src_g_c = {COLOR_W{bar_rgb_c[1]}};
      src_b_c = {COLOR_W{bar_rgb_c[0]}};
    end
`endif
    if (tick_q) begin
      // First tick after reset re-issues (0,0) as a new frame instead of advancing
      if (start_q) begin
        start_d = 1'b0;
        frame_d = 1'b1;
      end else if (h_q == CNT_W'(H_TOTAL - 1)) begin
        h_d = '0;
        if (v_q == CNT_W'(V_TOTAL - 1)) begin
          v_d     = '0;
          frame_d = 1'b1;
        end else begin
          v_d = v_q + CNT_W'(1);
        end
      end else begin
        h_d = h_q + CNT_W'(1);
      end
      pipe_d[0] = flags_c;
      for (int i = 1; i < int'(PIPE_D); i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
      blank_d = flags_dly_c[0];
      hs_d    = flags_dly_c[1] ? HS_ON : ~HS_ON;
      vs_d    = flags_dly_c[2] ? VS_ON : ~VS_ON;
      r_d     = flags_dly_c[0] ? src_r_c : '0;
      g_d     = flags_dly_c[0] ? src_g_c : '0;
      b_d     = flags_dly_c[0] ? src_b_c : '0;
    end
  end

  always_ff @(posedge FPGA_Clock) begin
    if (!FPGA_Reset_N) begin
      div_q   <= '0;
      tick_q  <= 1'b0;
      vclk_q  <= 1'b0;
      start_q <= 1'b1;
      frame_q <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
      pipe_q  <= '0;
      blank_q <= 1'b0;
      hs_q    <= ~HS_ON;
      vs_q    <= ~VS_ON;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      div_q   <= div_d;
      tick_q  <= tick_d;
      vclk_q  <= vclk_d;
      start_q <= start_d;
      frame_q <= frame_d;
      h_q     <= h_d;
      v_q     <= v_d;
      pipe_q  <= pipe_d;
      blank_q <= blank_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign VGA_Clock   = vclk_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_BLANK_N = blank_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign H_COUNT     = h_q;
  assign V_COUNT     = v_q;
  assign Pixel_Req   = active_c;
  assign Pixel_Tick  = tick_q;
  assign Frame_Start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen_param.sv
// Bench for vga_timing_gen_param: small-frame instances checked cycle by cycle
// against an arithmetic model of tick timing, raster position and pipeline delay.
`timescale 1ns/1ps
module tb_vga_timing_gen_param;

  localparam int HA = 8, HF = 2, HSW = 3, HB = 3, HT = 16;
  localparam int VA = 4, VF = 1, VSW = 2, VB = 1, VT = 8;
  localparam int CW = 8, NW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [CW-1:0] r_s = '0, g_s = '0, b_s = '0, r_p = '0, g_p = '0, b_p = '0;
  logic [CW-1:0] vr_s, vg_s, vb_s, vr_p, vg_p, vb_p;
  logic          vclk_s, sync_s, blank_s, hs_s, vs_s, req_s, tick_s, frame_s;
  logic          vclk_p, sync_p, blank_p, hs_p, vs_p, req_p, tick_p, frame_p;
  logic [NW-1:0] h_s, v_s, h_p, v_p;

  int ecnt = 0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [CW-1:0] exp_s_r = '0, exp_s_g = '0, exp_s_b = '0, exp_p_g = '0, exp_p_b = '0;

  vga_timing_gen_param #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .CLK_DIV(2), .COLOR_W(CW),
    .CNT_W(NW), .HS_POL(0), .VS_POL(0), .PIPE_LAT(1)) dut_s (
    .FPGA_Clock(clk), .FPGA_Reset_N(rst_n), .R(r_s), .G(g_s), .B(b_s),
`ifdef VGA_TEST_PATTERN_EN
    .Pattern_Sel(1'b0),
`endif
    .VGA_R(vr_s), .VGA_G(vg_s), .VGA_B(vb_s), .VGA_Clock(vclk_s), .VGA_SYNC_N(sync_s),
    .VGA_BLANK_N(blank_s), .VGA_HS(hs_s), .VGA_VS(vs_s), .H_COUNT(h_s), .V_COUNT(v_s),
    .Pixel_Req(req_s), .Pixel_Tick(tick_s), .Frame_Start(frame_s));

  vga_timing_gen_param #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .CLK_DIV(2), .COLOR_W(CW),
    .CNT_W(NW), .HS_POL(1), .VS_POL(1), .PIPE_LAT(3)) dut_p (
    .FPGA_Clock(clk), .FPGA_Reset_N(rst_n), .R(r_p), .G(g_p), .B(b_p),
`ifdef VGA_TEST_PATTERN_EN
    .Pattern_Sel(1'b0),
`endif
    .VGA_R(vr_p), .VGA_G(vg_p), .VGA_B(vb_p), .VGA_Clock(vclk_p), .VGA_SYNC_N(sync_p),
    .VGA_BLANK_N(blank_p), .VGA_HS(hs_p), .VGA_VS(vs_p), .H_COUNT(h_p), .V_COUNT(v_p),
    .Pixel_Req(req_p), .Pixel_Tick(tick_p), .Frame_Start(frame_p));

`ifdef VGA_TEST_PATTERN_EN
  logic [CW-1:0] vr_t, vg_t, vb_t;
  logic          vclk_t, sync_t, blank_t, hs_t, vs_t, req_t, tick_t, frame_t;
  logic [NW-1:0] h_t, v_t;
  vga_timing_gen_param #(.V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .PIPE_LAT(1)) dut_t (
    .FPGA_Clock(clk), .FPGA_Reset_N(rst_n), .R(r_s), .G(g_s), .B(b_s), .Pattern_Sel(1'b1),
    .VGA_R(vr_t), .VGA_G(vg_t), .VGA_B(vb_t), .VGA_Clock(vclk_t), .VGA_SYNC_N(sync_t),
    .VGA_BLANK_N(blank_t), .VGA_HS(hs_t), .VGA_VS(vs_t), .H_COUNT(h_t), .V_COUNT(v_t),
    .Pixel_Req(req_t), .Pixel_Tick(tick_t), .Frame_Start(frame_t));
`endif

  // Reference model: everything derives from the number of clock edges since reset release.
  // Pixel ticks land on edges 3,5,7,...; the first one re-issues (0,0).
  function automatic int ticks_of(input int e);
    return (e >= 3) ? (e - 1) / 2 : 0;
  endfunction
  function automatic int cnt_pos(input int e);
    int t;
    t = ticks_of(e);
    return (t > 0) ? t - 1 : 0;
  endfunction
  function automatic bit is_act(input int p);
    return ((p % HT) < HA) && (((p / HT) % VT) < VA);
  endfunction
  function automatic bit is_hs(input int p);
    return ((p % HT) >= HA + HF) && ((p % HT) < HA + HF + HSW);
  endfunction
  function automatic bit is_vs(input int p);
    return (((p / HT) % VT) >= VA + VF) && (((p / HT) % VT) < VA + VF + VSW);
  endfunction
  function automatic bit out_valid(input int e, input int lat);
    return (ticks_of(e) > 0) && (ticks_of(e) - lat >= 1);
  endfunction
  function automatic int out_pos(input int e, input int lat);
    int src;
    src = ticks_of(e) - lat;
    return (src >= 2) ? src - 2 : 0;
  endfunction

  task automatic step();
    int p;
    @(posedge clk);
    if (!rst_n) begin
      ecnt = 0;
      {exp_s_r, exp_s_g, exp_s_b, exp_p_g, exp_p_b} = '0;
    end else begin
      ecnt++;
      if (ecnt >= 3 && ecnt % 2 == 1) begin
        if (out_valid(ecnt, 1) && is_act(out_pos(ecnt, 1))) {exp_s_r, exp_s_g, exp_s_b} = {r_s, g_s, b_s};
        else {exp_s_r, exp_s_g, exp_s_b} = '0;
        if (out_valid(ecnt, 3) && is_act(out_pos(ecnt, 3))) {exp_p_g, exp_p_b} = {g_p, b_p};
        else {exp_p_g, exp_p_b} = '0;
      end
    end
    @(negedge clk);
    r_s = CW'($urandom);
    g_s = CW'($urandom);
    b_s = CW'($urandom);
    g_p = CW'($urandom);
    b_p = CW'($urandom);
    p = out_pos(ecnt + 1, 3);
    r_p = CW'(p % HT);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if ({blank_s, hs_s, vs_s, sync_s} !== 4'b0110) begin
        n_bad++; $display("FAIL reset_sync_s got %b want 0110", {blank_s, hs_s, vs_s, sync_s});
      end
      n_cmp++;
      if ({h_s, v_s} !== '0) begin
        n_bad++; $display("FAIL reset_cnt_s got H=%0d V=%0d want 0 0", h_s, v_s);
      end
      n_cmp++;
      if ({vr_s, vg_s, vb_s} !== '0) begin
        n_bad++; $display("FAIL reset_rgb_s got %h want 0", {vr_s, vg_s, vb_s});
      end
      n_cmp++;
      if ({tick_s, frame_s, vclk_s} !== 3'b000) begin
        n_bad++; $display("FAIL reset_ctl_s got %b want 000", {tick_s, frame_s, vclk_s});
      end
      n_cmp++;
      if ({blank_p, hs_p, vs_p, sync_p} !== 4'b0000) begin
        n_bad++; $display("FAIL reset_sync_p got %b want 0000", {blank_p, hs_p, vs_p, sync_p});
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_divider();
    logic [1:0] want;
    for (int i = 0; i < 12; i++) begin
      step();
      want = {1'(ecnt >= 2 && ecnt % 2 == 0), 1'(ecnt >= 2 && ecnt % 2 == 0)};
      n_cmp++;
      if ({tick_s, vclk_s} !== want || {tick_p, vclk_p} !== want) begin
        n_bad++;
        $display("FAIL divider e=%0d got s=%b p=%b want %b", ecnt, {tick_s, vclk_s}, {tick_p, vclk_p}, want);
      end
    end
  endtask

  task automatic test_frame(input int ncyc);
    int p, op;
    logic [3:0] wctl;
    logic [2:0] wout;
    for (int i = 0; i < ncyc; i++) begin
      step();
      p = cnt_pos(ecnt);
      n_cmp++;
      if ({h_s, v_s} !== {NW'(p % HT), NW'((p / HT) % VT)}) begin
        n_bad++;
        $display("FAIL frame_cnt e=%0d got H=%0d V=%0d want H=%0d V=%0d", ecnt, h_s, v_s, p % HT, (p / HT) % VT);
      end
      wctl = {1'(ecnt >= 2 && ecnt % 2 == 0), 1'(ecnt >= 2 && ecnt % 2 == 0),
              1'(ecnt >= 3 && ecnt % 2 == 1 && ((ticks_of(ecnt) - 1) % (HT * VT)) == 0), is_act(p)};
      n_cmp++;
      if ({tick_s, vclk_s, frame_s, req_s} !== wctl) begin
        n_bad++;
        $display("FAIL frame_ctl e=%0d got %b want %b", ecnt, {tick_s, vclk_s, frame_s, req_s}, wctl);
      end
      op = out_pos(ecnt, 1);
      wout = out_valid(ecnt, 1) ? {is_act(op), ~is_hs(op), ~is_vs(op)} : 3'b011;
      n_cmp++;
      if ({blank_s, hs_s, vs_s} !== wout) begin
        n_bad++;
        $display("FAIL frame_sync e=%0d got %b want %b", ecnt, {blank_s, hs_s, vs_s}, wout);
      end
      n_cmp++;
      if ({vr_s, vg_s, vb_s} !== {exp_s_r, exp_s_g, exp_s_b}) begin
        n_bad++;
        $display("FAIL frame_rgb e=%0d got %h want %h", ecnt, {vr_s, vg_s, vb_s}, {exp_s_r, exp_s_g, exp_s_b});
      end
    end
  endtask

  task automatic test_pipe_lat(input int ncyc);
    int p, op;
    bit ov;
    logic [2:0] wout;
    logic [CW-1:0] wr;
    for (int i = 0; i < ncyc; i++) begin
      step();
      p = cnt_pos(ecnt);
      n_cmp++;
      if ({h_p, v_p, frame_p} !== {NW'(p % HT), NW'((p / HT) % VT),
          1'(ecnt >= 3 && ecnt % 2 == 1 && ((ticks_of(ecnt) - 1) % (HT * VT)) == 0)}) begin
        n_bad++; $display("FAIL pipe_cnt e=%0d got H=%0d V=%0d F=%b", ecnt, h_p, v_p, frame_p);
      end
      ov = out_valid(ecnt, 3);
      op = out_pos(ecnt, 3);
      wout = ov ? {is_act(op), is_hs(op), is_vs(op)} : 3'b000;
      n_cmp++;
      if ({blank_p, hs_p, vs_p} !== wout) begin
        n_bad++; $display("FAIL pipe_sync e=%0d got %b want %b", ecnt, {blank_p, hs_p, vs_p}, wout);
      end
      wr = (ov && is_act(op)) ? CW'(op % HT) : '0;
      n_cmp++;
      if ({vr_p, vg_p, vb_p} !== {wr, exp_p_g, exp_p_b}) begin
        n_bad++;
        $display("FAIL pipe_rgb e=%0d got %h want %h", ecnt, {vr_p, vg_p, vb_p}, {wr, exp_p_g, exp_p_b});
      end
    end
  endtask

  task automatic test_mid_reset();
    int p;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      step();
      p = cnt_pos(ecnt);
      if (p % HT == 5 && (p / HT) % VT == 2) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++; $display("FAIL midrst_reach got no H=5 V=2 within 600 cycles want reached");
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++;
    if ({h_s, v_s, h_p, v_p, frame_s, blank_s} !== '0) begin
      n_bad++;
      $display("FAIL midrst_clear got Hs=%0d Vs=%0d Hp=%0d Vp=%0d F=%b BL=%b want all 0",
               h_s, v_s, h_p, v_p, frame_s, blank_s);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      if (ecnt == 3) begin
        n_cmp++;
        if ({frame_s, frame_p, h_s, v_s} !== {2'b11, NW'(0), NW'(0)}) begin
          n_bad++;
          $display("FAIL midrst_frame got Fs=%b Fp=%b H=%0d V=%0d want 1 1 0 0", frame_s, frame_p, h_s, v_s);
        end
      end
    end
  endtask

`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern();
    int p;
    int bars [8] = '{7, 6, 3, 2, 5, 4, 1, 0};
    logic [3*CW-1:0] want;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 1290; i++) begin
      step();
      p = out_pos(ecnt, 1);
      if (ticks_of(ecnt) >= 2 && p < 640 && (p < 80 || p >= 560 || i % 37 == 0)) begin
        want = {{CW{1'(bars[p / 80] >> 2)}}, {CW{1'(bars[p / 80] >> 1)}}, {CW{1'(bars[p / 80])}}};
        n_cmp++;
        if ({vr_t, vg_t, vb_t} !== want) begin
          n_bad++; $display("FAIL pattern px=%0d got %h want %h", p, {vr_t, vg_t, vb_t}, want);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_divider();
    test_frame(3 * 256 + 8);
    test_pipe_lat(300);
    test_mid_reset();
    test_frame(40);
`ifdef VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
